// File: rtl/acia_pkg.sv
// acia_pkg: types and constants shared by the ACIA transmitter and receiver
package acia_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} acia_state_e;
    localparam int ACIA_DATA_BITS = 8;
    localparam int ACIA_FRAME_BITS = 10;
    localparam logic ACIA_START_LVL = 1'b0;
    localparam logic ACIA_STOP_LVL = 1'b1;
endpackage

// File: rtl/acia_tx_if.sv
// acia_tx_if: CPU-side write port and serial line of the ACIA transmitter
interface acia_tx_if;
    logic [7:0] tx_dat;
    logic tx_start;
    logic tx_serial;
    logic tx_busy;
    logic tx_full;
    modport master (output tx_dat, tx_start, input tx_serial, tx_busy, tx_full);
    modport slave (input tx_dat, tx_start, output tx_serial, tx_busy, tx_full);
endinterface

// File: rtl/acia_tx_fifo.sv
// acia_tx_fifo: show-ahead synchronous byte FIFO, 2^AW entries, registered full
module acia_tx_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] wdat,
    input  logic       rd,
    output logic [7:0] rdat,
    output logic       empty,
    output logic       full
);
    localparam int DEPTH = 1 << AW;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_n;
    logic do_wr, do_rd;
    assign do_rd = rd && !empty;
    // a full FIFO still takes a write when the same edge pops
    assign do_wr = wr && (cnt != (AW+1)'(DEPTH) || do_rd);
    assign cnt_n = cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    assign empty = cnt == '0;
    assign rdat = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            full <= 1'b0;
        end else begin
            wp <= wp + AW'(do_wr);
            rp <= rp + AW'(do_rd);
            cnt <= cnt_n;
            full <= cnt_n == (AW+1)'(DEPTH);
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdat;
    end
endmodule

// File: rtl/acia_tx.sv
// acia_tx: 8N1 serial transmitter; define ACIA_TX_FIFO_EN to queue writes in acia_tx_fifo
module acia_tx
    import acia_pkg::*;
#(
    parameter int SCW = 8,
    parameter int SYM_CNT = 139,
    parameter int FIFO_AW = 2
) (
    input logic clk,
    input logic rst_n,
    acia_tx_if.slave bus
);
    localparam logic [SCW-1:0] RELOAD = SCW'(SYM_CNT - 1);
    if (SYM_CNT < 2 || SYM_CNT >= (1 << SCW) || FIFO_AW < 1) begin : g_bad_cfg
        $error("acia_tx: SYM_CNT or FIFO_AW out of range");
    end
    acia_state_e state, state_n;
    logic [SCW-1:0] rate, rate_n;
    logic [2:0] bitc, bitc_n;
    logic [7:0] sh, sh_n, din;
    logic line, line_n, tick, avail, load;
`ifdef ACIA_TX_FIFO_EN
    logic fifo_empty, fifo_full;
    acia_tx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .wr(bus.tx_start),
        .wdat(bus.tx_dat),
        .rd(load),
        .rdat(din),
        .empty(fifo_empty),
        .full(fifo_full)
    );
    assign avail = !fifo_empty;
    assign bus.tx_busy = state != IDLE || !fifo_empty;
    assign bus.tx_full = fifo_full;
`else
    assign avail = bus.tx_start;
    assign din = bus.tx_dat;
    assign bus.tx_busy = state != IDLE;
    assign bus.tx_full = state != IDLE;
`endif
    assign tick = rate == '0;
    // the last stop-bit clock may load the next byte so frames run back to back
    assign load = avail && (state == IDLE || (state == STOP && tick));
    assign bus.tx_serial = line;
    always_comb begin
        state_n = state;
        rate_n = rate;
        bitc_n = bitc;
        sh_n = sh;
        line_n = line;
        if (load) begin
            state_n = START;
            rate_n = RELOAD;
            bitc_n = 3'd7;
            sh_n = din;
            line_n = ACIA_START_LVL;
        end else if (state != IDLE) begin
            rate_n = tick ? RELOAD : rate - SCW'(1);
            if (tick) begin
                case (state)
                    START: begin
                        state_n = DATA;
                        line_n = sh[0];
                    end
                    DATA: begin
                        sh_n = sh >> 1;
                        bitc_n = bitc - 3'd1;
                        state_n = bitc == 3'd0 ? STOP : DATA;
                        line_n = bitc == 3'd0 ? ACIA_STOP_LVL : sh[1];
                    end
                    default: begin
                        state_n = IDLE;
                        line_n = ACIA_STOP_LVL;
                    end
                endcase
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rate <= '0;
            bitc <= '0;
            sh <= '0;
            line <= ACIA_STOP_LVL;
        end else begin
            state <= state_n;
            rate <= rate_n;
            bitc <= bitc_n;
            sh <= sh_n;
            line <= line_n;
        end
    end
endmodule

// File: tb/tb_acia_tx.sv
// tb_acia_tx: frame-level model plus line decoder checking acia_tx with SYM_CNT=4
module tb_acia_tx;
    localparam int S = 4;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    acia_tx_if bus ();
    acia_tx #(.SCW(8), .SYM_CNT(S), .FIFO_AW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pos counts clocks since the start-bit edge, -1 when idle
    int pos = -1;
    logic [7:0] cur = 8'h00;
    logic [7:0] q[$];
    always @(posedge clk or negedge rst_n) begin
        bit can_pop;
        logic st;
        logic [7:0] d;
        if (!rst_n) begin
            pos = -1;
            q.delete();
        end else begin
            st = bus.tx_start;
            d = bus.tx_dat;
`ifdef ACIA_TX_FIFO_EN
            can_pop = (pos < 0 || pos == 10 * S - 1) && q.size() > 0;
            if (pos >= 0) pos++;
            if (pos == 10 * S) pos = -1;
            if (can_pop) begin
                cur = q.pop_front();
                pos = 0;
            end
            if (st && (q.size() < D || can_pop)) q.push_back(d);
`else
            can_pop = 1'b0;
            if (pos < 0) begin
                if (st) begin
                    cur = d;
                    pos = 0;
                end
            end else begin
                pos++;
                if (pos == 10 * S) pos = -1;
            end
`endif
        end
    end

    function automatic logic exp_line();
        int k;
        if (pos < 0) return 1'b1;
        k = pos / S;
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : cur[k-1];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("line", bus.tx_serial, exp_line());
            chk("busy", bus.tx_busy, pos >= 0 || q.size() > 0);
`ifdef ACIA_TX_FIFO_EN
            chk("full", bus.tx_full, q.size() == D);
`else
            chk("full", bus.tx_full, pos >= 0);
`endif
        end
    end

    // independent line decoder: samples mid-bit, collects received bytes
    int dc = -1;
    logic [7:0] rsh;
    logic [7:0] rxq[$];
    always @(negedge clk) begin
        int k;
        if (!rst_n) dc = -1;
        else if (dc < 0) begin
            if (bus.tx_serial == 1'b0) dc = 0;
        end else begin
            dc++;
            if (dc % S == S / 2) begin
                k = dc / S;
                if (k == 0) chk("start_bit", bus.tx_serial, 0);
                else if (k <= 8) rsh[k-1] = bus.tx_serial;
                else begin
                    chk("stop_bit", bus.tx_serial, 1);
                    rxq.push_back(rsh);
                    dc = -1;
                end
            end
        end
    end

    task automatic send(logic [7:0] d);
        bus.tx_dat = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    task automatic expect_rx(string name, int n, logic [63:0] bytes);
        chk({name, "_count"}, rxq.size(), n);
        for (int i = 0; i < n && rxq.size() > 0; i++) chk(name, rxq.pop_front(), bytes[8*i +: 8]);
        rxq.delete();
    endtask

    initial begin
        int zeros;
        int busyc;
        logic [9:0] pat;
        logic samp[44];
        bus.tx_start = 1'b0;
        bus.tx_dat = 8'h00;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_line", bus.tx_serial, 1);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_full", bus.tx_full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        zeros = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx_serial !== 1'b1) zeros++;
        end
        chk("idle_quiet", zeros, 0);

        send(8'hA5);
        busyc = 0;
        for (int i = 0; i < 44; i++) begin
            samp[i] = bus.tx_serial;
            busyc += int'(bus.tx_busy);
            @(negedge clk);
        end
        pat = 10'b1101001010;
        for (int k = 0; k < 10; k++) chk("a5_bit", samp[k*S+2], pat[k]);
        chk("a5_start_edge", samp[3], 0);
        chk("a5_bit1_edge", samp[4], 1);
        chk("a5_after", samp[40], 1);
        chk("a5_busy_clocks", busyc, 40);
        expect_rx("a5_rx", 1, 64'hA5);

        send(8'h55);
        repeat (4) @(negedge clk);
`ifdef ACIA_TX_FIFO_EN
        chk("drop_full", bus.tx_full, 0);
`else
        chk("drop_full", bus.tx_full, 1);
`endif
        send(8'hFF);
        repeat (90) @(negedge clk);
`ifdef ACIA_TX_FIFO_EN
        expect_rx("drop_rx", 2, 64'hFF55);
`else
        expect_rx("drop_rx", 1, 64'h55);
`endif

        for (int i = 1; i <= 6; i++) begin
            bus.tx_dat = 8'(i);
            bus.tx_start = 1'b1;
            @(negedge clk);
        end
        bus.tx_start = 1'b0;
        repeat (55 * S) @(negedge clk);
`ifdef ACIA_TX_FIFO_EN
        expect_rx("burst_rx", 5, 64'h0504030201);
`else
        expect_rx("burst_rx", 1, 64'h01);
`endif

        send(8'h00);
        repeat (45) @(negedge clk);
        send(8'hFF);
        repeat (45) @(negedge clk);
        send(8'h3C);
        repeat (45) @(negedge clk);
        expect_rx("loop_rx", 3, 64'h3CFF00);

        send(8'h0F);
        repeat (21) @(negedge clk);
        chk("mid_line_low", bus.tx_serial, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_line", bus.tx_serial, 1);
        chk("mid_rst_busy", bus.tx_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_busy", bus.tx_busy, 0);
        expect_rx("post_rst_rx", 0, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acia_tx.md
# acia_tx

Asynchronous serial transmit submodule for the ACIA, the counterpart of the ACIA receiver. It accepts bytes from the 6502 bus interface and serialises them as 8N1 frames at a fixed symbol rate: one start bit (0), eight data bits LSB first, one stop bit (1). An optional small FIFO lets the CPU queue bytes so that frames go out back-to-back.

## Interface
- SCW, 8, width of the symbol-rate counter.
- SYM_CNT, 139, clocks per bit: 115200 bps at a 16 MHz clk. Legal range 2 to 2^SCW − 1.
- FIFO_AW, 2, FIFO address width, giving 2^FIFO_AW entries. Used only when ACIA_TX_FIFO_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_dat  in  8  byte to send; sampled on the cycle tx_start is high.
- tx_start  in  1  one-cycle write strobe.
- tx_serial  out  1  serial line, registered; idles at 1.
- tx_busy  out  1  transmitter not idle, or data still pending.
- tx_full  out  1  write would be dropped.

## Operation
- Reset (rst_n low, asynchronous) sets the following, with tx_serial driven high during reset:
  - tx_serial=1, tx_busy=0, tx_full=0.
  - State IDLE; counters 0; FIFO empty.
- The state machine has four states: IDLE, START, DATA, STOP.
  - IDLE → START when a byte is available. The byte is loaded into the 8-bit shift register, the bit counter is set to 7, the rate counter is set to SYM_CNT−1, and tx_serial is set to 0.
  - Each state holds for exactly SYM_CNT clocks. The rate counter counts down, and state advances when it reaches 0, at which point the counter reloads to SYM_CNT−1.
  - START → DATA: tx_serial takes shift register bit 0.
  - DATA: at each bit end the register shifts right. When the bit counter is 0, go to STOP with tx_serial=1; otherwise decrement the bit counter and output the next bit.
  - STOP → IDLE at bit end. If a byte is already available at that edge, go straight to START instead, with no idle gap.
- Write acceptance, no-FIFO build:
  - A write is accepted only in IDLE.
  - tx_full equals tx_busy, which is high in START, DATA and STOP.
  - A write while busy is silently dropped.
- Write acceptance, FIFO build:
  - Writes push into the FIFO; the state machine pops from it.
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
  - A push while full (with no simultaneous pop) is dropped.
  - tx_full = (count == 2^FIFO_AW).
  - tx_busy = (state != IDLE) or (count != 0).
- Arithmetic:
  - The rate counter is SCW bits.
  - The bit counter is 3 bits.
  - FIFO pointers are FIFO_AW bits and wrap modulo depth; the count is FIFO_AW+1 bits.
- Reset mid-frame aborts the frame. The line returns to 1 immediately (asynchronously), and queued data is discarded.

## Timing
- Write latency, no-FIFO build: tx_start high in cycle N (in IDLE) gives tx_serial=0 and tx_busy=1 from the edge ending cycle N.
- Write latency, FIFO build: two edges. The push happens at edge N, and the pop/load at edge N+1 when idle.
- Frame length:
  - Exactly 10·SYM_CNT clocks from the start-bit edge to the return to IDLE.
  - tx_busy falls on that same edge, if nothing is pending.
- Bit k (0 = start, 9 = stop) occupies clocks [k·SYM_CNT, (k+1)·SYM_CNT) relative to the start-bit edge.
- Back-to-back frames (FIFO build): the next start bit begins on the clock immediately after the last stop-bit clock, so the period is exactly 10·SYM_CNT.
- tx_full in the no-FIFO build is combinationally equal to tx_busy. In the FIFO build it is registered from the count.

## Configuration
- ACIA_TX_FIFO_EN
  - Defined: a FIFO of 2^FIFO_AW × 8 bits sits between the write port and the state machine. It is built from the sub-module below, and tx_busy/tx_full follow the FIFO rules above.
  - Undefined: no FIFO and FIFO_AW is ignored. There is a single holding path straight into the shift register, writes are accepted only in IDLE, and tx_full equals tx_busy.
- Port list is identical in both builds.

## Structure
- Shared package acia_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - ACIA_DATA_BITS = 8 and ACIA_FRAME_BITS = 10;
  - start/stop level constants (0/1).
- Sub-module acia_tx_fifo is the synchronous FIFO:
  - ports clk, rst_n, wr, wdat, rd, rdat, empty, full;
  - show-ahead read, so rdat is valid whenever not empty;
  - instantiated only under ACIA_TX_FIFO_EN.
- Parameters SCW/SYM_CNT stay consistent with the receiver so that loopback works with identical values.

## Test plan
- Reset/idle: hold rst_n low, then release → tx_serial=1, tx_busy=0, tx_full=0, and no line activity for 100 clocks.
- Single byte: SYM_CNT=4, write 8'hA5 → line 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks, and tx_busy high for exactly 40 clocks.
- Dropped write (no FIFO): write 8'h55, then 8'hFF 5 clocks later → only the 8'h55 frame appears, and tx_full is high during the frame.
- FIFO burst (ACIA_TX_FIFO_EN, FIFO_AW=2):
  - write 8'h01, 02, 03, 04, 05 on consecutive cycles → 8'h01 is loaded, 02–05 fill the FIFO, tx_full rises, and nothing is dropped;
  - a 6th write while full is dropped;
  - five frames go out with no idle gap: 50·SYM_CNT clocks total.
- Loopback: feed tx_serial into the receiver with the same SYM_CNT and send 8'h00, 8'hFF, 8'h3C → each byte is received, rx_stb pulses, and rx_err=0.
- Reset mid-frame: deassert rst_n during bit 4 of 8'h0F → tx_serial goes to 1 asynchronously. After release the FIFO is empty, tx_busy=0, and no further frame is sent.
